uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART TX serializer between N byte-stream requesters, such as cores, a debug unit and a boot ROM printer.
Once a requester is granted, it keeps the line for a whole message, so output lines from different sources are never interleaved mid-line.
A message ends at an end-of-line byte, at a burst limit, or when the owner goes idle for too long.
Sits between the requesters' valid/ready byte ports and the single UART TX core (tx_valid/tx_ready byte interface).

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester byte streams, the single UART TX byte port and status.
// The slave modport is the arbiter; the master modport is whoever drives the
// requesters and the TX core side (the integration wrapper or a bench).
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int SW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic [SW-1:0]      tx_src;
  logic               tx_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_valid, tx_data, tx_src, grant, busy
  );

  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_valid, tx_data, tx_src, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one UART TX serializer shared by N_REQ byte streams.
// An owner keeps the line for a whole message so text lines never interleave;
// the grant ends on an EOL byte, after MAX_BURST bytes, or after the owner
// has been idle for IDLE_TIMEOUT cycles.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no owner; scan for next valid requester after 'last'
//   LOCKED | owner 'owner' may push bytes into the output register
module uart_tx_arbiter #(
  parameter int         N_REQ        = 4,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 256,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input logic            clk_i,
  input logic            rst_ni,
  uart_tx_arbiter_if.slave bus
);
  localparam int SW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state;
  logic [SW-1:0] last;
  logic [SW-1:0] owner;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] idle_cnt;

  logic          slot_free;
  logic          own_valid;
  logic [7:0]    own_data;
  logic          accept;
  logic          release_now;
  logic [SW-1:0] pick;
  logic          pick_found;
  int            cand;

  assign slot_free = !bus.tx_valid || bus.tx_ready;
  assign accept    = (state == LOCKED) && own_valid && slot_free;
  assign bus.busy  = (state == LOCKED) || bus.tx_valid;

  // a new owner may stall on slot_free, but a stalled owner holding valid is
  // never idle, so back-pressure alone cannot cause a timeout release
  assign release_now = (state == LOCKED) &&
                       ((accept && own_data == EOL_CHAR) ||
                        (accept && burst_cnt == BW'(MAX_BURST - 1)) ||
                        (!own_valid && idle_cnt == TW'(IDLE_TIMEOUT - 1)));

  // select the current owner's valid and byte
  always_comb begin
    own_valid = 1'b0;
    own_data  = 8'h00;
    for (int j = 0; j < N_REQ; j++) begin
      if (owner == SW'(j)) begin
        own_valid = bus.req_valid[j];
        own_data  = bus.req_data[8*j +: 8];
      end
    end
  end

  // only the owner sees ready, and only while the output slot can take a byte
  always_comb begin
    bus.req_ready = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (state == LOCKED && owner == SW'(j)) bus.req_ready[j] = slot_free;
    end
  end

  // round-robin scan starting just after the previous owner
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last) + k) % N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!pick_found && j == cand && bus.req_valid[j]) begin
          pick       = SW'(j);
          pick_found = 1'b1;
        end
      end
    end
  end

  // owner FSM, burst/idle counters and the single-entry output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      last         <= SW'(N_REQ - 1);
      owner        <= '0;
      bus.grant    <= '0;
      burst_cnt    <= '0;
      idle_cnt     <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.tx_src   <= '0;
    end else begin
      if (accept) begin
        bus.tx_valid <= 1'b1;
        bus.tx_data  <= own_data;
        bus.tx_src   <= owner;
      end else if (bus.tx_ready) begin
        bus.tx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            owner     <= pick;
            bus.grant <= N_REQ'(1) << pick;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (release_now) begin
            last      <= owner;
            bus.grant <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            state     <= IDLE;
          end else begin
            if (accept) burst_cnt <= burst_cnt + BW'(1);
            idle_cnt <= own_valid ? '0 : idle_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N_REQ=4, MAX_BURST=4, IDLE_TIMEOUT=8.
module tb_uart_tx_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni;

  int checks   = 0;
  int failures = 0;

  logic [7:0] msg [4][16];
  int         len [4];
  int         pos [4];
  logic [3:0] en;

  logic [7:0] out_d [$];
  logic [1:0] out_s [$];
  logic [7:0] exp_d [$];
  logic [1:0] exp_s [$];

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(
    .N_REQ(4), .MAX_BURST(4), .IDLE_TIMEOUT(8), .EOL_CHAR(8'h0A)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    logic [3:0]  v;
    logic [31:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && pos[i] < len[i]) begin
        v[i]       = 1'b1;
        d[8*i +: 8] = msg[i][pos[i]];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    #1;
  endtask

  task automatic load(input int r, input string s);
    for (int i = 0; i < s.len(); i++) msg[r][i] = s[i];
    len[r] = s.len();
    pos[r] = 0;
    en[r]  = 1'b1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    en = '0;
  endtask

  // one clock: sample handshakes mid-cycle, advance requesters after the edge
  task automatic cyc();
    logic [3:0] hs;
    @(negedge clk_i);
    hs = bus.req_valid & bus.req_ready;
    if (bus.tx_valid && bus.tx_ready) begin
      out_d.push_back(bus.tx_data);
      out_s.push_back(bus.tx_src);
    end
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) pos[i]++;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic ex_str(input string s, input logic [1:0] src);
    for (int i = 0; i < s.len(); i++) begin
      exp_d.push_back(s[i]);
      exp_s.push_back(src);
    end
  endtask

  task automatic cmp_out(input string tag);
    chk({tag, " count"}, 32'(out_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < out_d.size()) begin
        chk($sformatf("%s[%0d] data", tag, i), 32'(out_d[i]), 32'(exp_d[i]));
        chk($sformatf("%s[%0d] src", tag, i), 32'(out_s[i]), 32'(exp_s[i]));
      end
    end
    out_d.delete();
    out_s.delete();
    exp_d.delete();
    exp_s.delete();
  endtask

  initial begin
    rst_ni       = 1'b0;
    bus.tx_ready = 1'b1;
    clear_reqs();
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst tx_src", 32'(bus.tx_src), 32'h0);
    chk("rst grant", 32'(bus.grant), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    rst_ni = 1'b1;

    // single requester 1 sends "AB\n"
    load(1, "AB\n");
    drive();
    chk("t1 grant before arb", 32'(bus.grant), 32'h0);
    chk("t1 ready in idle", 32'(bus.req_ready), 32'h0);
    cyc();
    chk("t1 grant", 32'(bus.grant), 32'b0010);
    chk("t1 ready", 32'(bus.req_ready), 32'b0010);
    chk("t1 busy", 32'(bus.busy), 32'h1);
    cyc();
    chk("t1 byte0 valid", 32'(bus.tx_valid), 32'h1);
    chk("t1 byte0 data", 32'(bus.tx_data), 32'h41);
    chk("t1 byte0 src", 32'(bus.tx_src), 32'h1);
    cyc();
    chk("t1 byte1 data", 32'(bus.tx_data), 32'h42);
    cyc();
    chk("t1 byte2 data", 32'(bus.tx_data), 32'h0A);
    chk("t1 grant after eol", 32'(bus.grant), 32'h0);
    cyc();
    chk("t1 drained valid", 32'(bus.tx_valid), 32'h0);
    chk("t1 drained busy", 32'(bus.busy), 32'h0);
    ex_str("AB\n", 2'd1);
    cmp_out("t1 out");

    // requesters 0 and 2 valid straight out of reset
    rst_ni = 1'b0;
    clear_reqs();
    load(0, "X\n");
    load(2, "X\n");
    drive();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    run(12);
    ex_str("X\n", 2'd0);
    ex_str("X\n", 2'd2);
    cmp_out("t2 out");

    // burst limit: 3 streams 10 bytes, 1 waits with a short line
    clear_reqs();
    load(3, "0123456789");
    load(1, "Q\n");
    drive();
    run(40);
    ex_str("0123", 2'd3);
    ex_str("Q\n", 2'd1);
    ex_str("456789", 2'd3);
    cmp_out("t3 out");
    chk("t3 grant released", 32'(bus.grant), 32'h0);

    // idle timeout: 0 sends one byte then goes quiet, 2 waits
    clear_reqs();
    load(0, "Z");
    load(2, "K\n");
    drive();
    cyc();
    chk("t4 grant owner0", 32'(bus.grant), 32'b0001);
    cyc();
    chk("t4 valid0 dropped", 32'(bus.req_valid[0]), 32'h0);
    run(7);
    chk("t4 still owned after 7 idle", 32'(bus.grant), 32'b0001);
    cyc();
    chk("t4 released after 8 idle", 32'(bus.grant), 32'h0);
    cyc();
    chk("t4 grant owner2", 32'(bus.grant), 32'b0100);
    run(6);
    ex_str("Z", 2'd0);
    ex_str("K\n", 2'd2);
    cmp_out("t4 out");

    // back-pressure: tx_ready low for 20 cycles with a byte pending
    clear_reqs();
    bus.tx_ready = 1'b0;
    load(1, "Hi\n");
    drive();
    cyc();
    chk("t5 grant", 32'(bus.grant), 32'b0010);
    chk("t5 ready slot empty", 32'(bus.req_ready), 32'b0010);
    cyc();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t5 stall%0d data", i), 32'(bus.tx_data), 32'h48);
      chk($sformatf("t5 stall%0d src", i), 32'(bus.tx_src), 32'h1);
      chk($sformatf("t5 stall%0d ready", i), 32'(bus.req_ready), 32'h0);
      chk($sformatf("t5 stall%0d grant", i), 32'(bus.grant), 32'b0010);
      cyc();
    end
    bus.tx_ready = 1'b1;
    #1;
    chk("t5 ready on tx_ready", 32'(bus.req_ready), 32'b0010);
    run(8);
    ex_str("Hi\n", 2'd1);
    cmp_out("t5 out");

    // reset while a byte sits in the output register
    clear_reqs();
    bus.tx_ready = 1'b0;
    load(3, "RS\n");
    drive();
    cyc();
    chk("t6 grant owner3", 32'(bus.grant), 32'b1000);
    cyc();
    chk("t6 pending valid", 32'(bus.tx_valid), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("t6 rst tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("t6 rst grant", 32'(bus.grant), 32'h0);
    chk("t6 rst busy", 32'(bus.busy), 32'h0);
    clear_reqs();
    out_d.delete();
    out_s.delete();
    bus.tx_ready = 1'b1;
    load(0, "A\n");
    load(3, "A\n");
    drive();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc();
    chk("t6 priority owner0", 32'(bus.grant), 32'b0001);
    run(10);
    ex_str("A\n", 2'd0);
    ex_str("A\n", 2'd3);
    cmp_out("t6 out");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
